// File: rtl/conv_acc_pkg.sv
// Shared constants, activation encodings and width helpers for the
// accumulating 3x3 conv kernel array.
package conv_acc_pkg;

    localparam int TAPS        = 9;
    localparam int LEAKY_SHIFT = 3;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_RSVD  = 2'd3
    } act_mode_e;

    function automatic int prod_w(input int data_w);
        return 2 * data_w;
    endfunction

    // Nine products need four extra bits of headroom.
    function automatic int tap_sum_w(input int data_w);
        return 2 * data_w + 4;
    endfunction

    function automatic int tree_w(input int data_w, input int n_ich);
        return 2 * data_w + 4 + $clog2(n_ich);
    endfunction

endpackage

// File: rtl/conv_pe_dot9.sv
// One 3x3 dot product: registered signed products, then a registered
// nine-tap sum (two cycles from inputs to sum).
module conv_pe_dot9
    import conv_acc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SUM_W  = tap_sum_w(DATA_W)
) (
    input  logic                     clk,
    input  logic [TAPS*DATA_W-1:0]   ifm,
    input  logic [TAPS*DATA_W-1:0]   weight,
    output logic signed [SUM_W-1:0]  sum
);

    localparam int PROD_W = prod_w(DATA_W);

    logic signed [PROD_W-1:0] prod_q [TAPS];
    logic signed [SUM_W-1:0]  tap_sum;

    always_ff @(posedge clk) begin
        for (int k = 0; k < TAPS; k++) begin
            prod_q[k] <= $signed(ifm[k*DATA_W +: DATA_W]) * $signed(weight[k*DATA_W +: DATA_W]);
        end
    end

    always_comb begin
        tap_sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            tap_sum = tap_sum + SUM_W'(prod_q[k]);
        end
    end

    always_ff @(posedge clk) begin
        sum <= tap_sum;
    end

endmodule

// File: rtl/conv_kernel_array_acc.sv
// N_OCH x N_ICH 3x3 conv kernel array with cross-beat accumulation,
// bias, requantisation, activation and saturation (5-stage pipeline).
module conv_kernel_array_acc
    import conv_acc_pkg::*;
#(
    parameter int N_ICH  = 8,
    parameter int N_OCH  = 8,
    parameter int DATA_W = 8,
    parameter int BIAS_W = 18,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 18
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic                                ic_first,
    input  logic                                ic_last,
    input  logic [N_ICH*TAPS*DATA_W-1:0]        ifm_win,
    input  logic [N_OCH*N_ICH*TAPS*DATA_W-1:0]  weight,
    input  logic [N_OCH*BIAS_W-1:0]             bias_in,
    input  logic                                bias_valid,
    input  logic [1:0]                          act_mode,
    input  logic [4:0]                          out_shift,
    output logic                                out_valid,
    output logic [N_OCH*OUT_W-1:0]              ofm,
    output logic                                sat_any,
    output logic                                err_seq
);

    localparam int SUM_W  = tap_sum_w(DATA_W);
    localparam int TREE_W = tree_w(DATA_W, N_ICH);
    localparam int X_W    = ACC_W + 1;
    localparam logic signed [X_W-1:0] OUT_MAX = {{(X_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [X_W-1:0] OUT_MIN = {{(X_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Handshake: in_valid has no ready; every cycle with in_valid=1 is an
    // accepted beat, and out_valid is a single-cycle pulse with no stall.
    logic                     group_open;
    logic                     eff_first;
    logic signed [BIAS_W-1:0] bias_q [N_OCH];

    logic                     v_q     [1:4];
    logic                     first_q [1:3];
    logic                     last_q  [1:4];
    logic [1:0]               mode_q  [1:4];
    logic [4:0]               shift_q [1:4];
    logic signed [BIAS_W-1:0] bias_p  [1:3][N_OCH];

    logic signed [SUM_W-1:0]  pe_sum   [N_OCH][N_ICH];
    logic signed [TREE_W-1:0] tree_sum [N_OCH];
    logic signed [TREE_W-1:0] tree_q   [N_OCH];
    logic signed [ACC_W-1:0]  acc      [N_OCH];

    logic signed [X_W-1:0]    rnd;
    logic signed [X_W-1:0]    x_shr [N_OCH];
    logic signed [X_W-1:0]    x_act [N_OCH];
    logic [N_OCH*OUT_W-1:0]   ofm_c;
    logic                     sat_c;

    // A beat with no open group always starts a fresh accumulation.
    assign eff_first = ic_first | ~group_open;

    always_ff @(posedge clk) begin
        if (rst) begin
            group_open <= 1'b0;
            err_seq    <= 1'b0;
            for (int o = 0; o < N_OCH; o++) bias_q[o] <= '0;
            for (int s = 1; s <= 4; s++) v_q[s] <= 1'b0;
        end else begin
            if (bias_valid) begin
                for (int o = 0; o < N_OCH; o++) bias_q[o] <= bias_in[o*BIAS_W +: BIAS_W];
            end
            if (in_valid) begin
                group_open <= ~ic_last;
                // first with a group open, or non-first with none open
                if (ic_first == group_open) err_seq <= 1'b1;
            end
            v_q[1] <= in_valid;
            for (int s = 2; s <= 4; s++) v_q[s] <= v_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        first_q[1] <= eff_first;
        last_q[1]  <= ic_last;
        mode_q[1]  <= act_mode;
        shift_q[1] <= out_shift;
        bias_p[1]  <= bias_q;
        for (int s = 2; s <= 3; s++) begin
            first_q[s] <= first_q[s-1];
            bias_p[s]  <= bias_p[s-1];
        end
        for (int s = 2; s <= 4; s++) begin
            last_q[s]  <= last_q[s-1];
            mode_q[s]  <= mode_q[s-1];
            shift_q[s] <= shift_q[s-1];
        end
    end

    for (genvar o = 0; o < N_OCH; o++) begin : g_och
        for (genvar i = 0; i < N_ICH; i++) begin : g_ich
            conv_pe_dot9 #(
                .DATA_W (DATA_W),
                .SUM_W  (SUM_W)
            ) u_pe (
                .clk    (clk),
                .ifm    (ifm_win[i*TAPS*DATA_W +: TAPS*DATA_W]),
                .weight (weight[(o*N_ICH+i)*TAPS*DATA_W +: TAPS*DATA_W]),
                .sum    (pe_sum[o][i])
            );
        end
    end

    always_comb begin
        for (int o = 0; o < N_OCH; o++) begin
            tree_sum[o] = '0;
            for (int i = 0; i < N_ICH; i++) begin
                tree_sum[o] = tree_sum[o] + TREE_W'(pe_sum[o][i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        tree_q <= tree_sum;
    end

    // Wraps modulo 2^ACC_W; holds through in_valid=0 gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < N_OCH; o++) acc[o] <= '0;
        end else if (v_q[3]) begin
            for (int o = 0; o < N_OCH; o++) begin
                acc[o] <= (first_q[3] ? ACC_W'(bias_p[3][o]) : acc[o]) + ACC_W'(tree_q[o]);
            end
        end
    end

    // One extra bit keeps the rounding add from overflowing.
    always_comb begin
        rnd = '0;
        if (shift_q[4] != 5'd0) rnd = X_W'(1) << (shift_q[4] - 5'd1);
        ofm_c = '0;
        sat_c = 1'b0;
        for (int o = 0; o < N_OCH; o++) begin
            x_shr[o] = (X_W'(acc[o]) + rnd) >>> shift_q[4];
            x_act[o] = x_shr[o];
            case (act_mode_e'(mode_q[4]))
                ACT_RELU:  if (x_shr[o][X_W-1]) x_act[o] = '0;
                ACT_LEAKY: if (x_shr[o][X_W-1]) x_act[o] = x_shr[o] >>> LEAKY_SHIFT;
                default:   x_act[o] = x_shr[o];
            endcase
            if (x_act[o] > OUT_MAX) begin
                ofm_c[o*OUT_W +: OUT_W] = OUT_MAX[OUT_W-1:0];
                sat_c = 1'b1;
            end else if (x_act[o] < OUT_MIN) begin
                ofm_c[o*OUT_W +: OUT_W] = OUT_MIN[OUT_W-1:0];
                sat_c = 1'b1;
            end else begin
                ofm_c[o*OUT_W +: OUT_W] = x_act[o][OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            ofm       <= '0;
            sat_any   <= 1'b0;
        end else begin
            out_valid <= v_q[4] & last_q[4];
            if (v_q[4] & last_q[4]) begin
                ofm     <= ofm_c;
                sat_any <= sat_c;
            end
        end
    end

endmodule

// File: tb/tb_conv_kernel_array_acc.sv
// Randomised scoreboard bench for conv_kernel_array_acc: a plain-arithmetic
// group model pushes expected outputs, a negedge monitor pops and compares.
module tb_conv_kernel_array_acc;

    localparam int N_ICH  = 8;
    localparam int N_OCH  = 8;
    localparam int DATA_W = 8;
    localparam int BIAS_W = 18;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 18;
    localparam int TAPS   = 9;
    localparam int OFM_W  = N_OCH * OUT_W;
    localparam longint OUT_MAX = (longint'(1) << (OUT_W - 1)) - 1;
    localparam longint OUT_MIN = -(longint'(1) << (OUT_W - 1));

    logic                               clk = 1'b0;
    logic                               rst;
    logic                               in_valid;
    logic                               ic_first;
    logic                               ic_last;
    logic [N_ICH*TAPS*DATA_W-1:0]       ifm_win;
    logic [N_OCH*N_ICH*TAPS*DATA_W-1:0] weight;
    logic [N_OCH*BIAS_W-1:0]            bias_in;
    logic                               bias_valid;
    logic [1:0]                         act_mode;
    logic [4:0]                         out_shift;
    logic                               out_valid;
    logic [OFM_W-1:0]                   ofm;
    logic                               sat_any;
    logic                               err_seq;

    conv_kernel_array_acc #(
        .N_ICH(N_ICH), .N_OCH(N_OCH), .DATA_W(DATA_W),
        .BIAS_W(BIAS_W), .ACC_W(ACC_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ic_first(ic_first),
        .ic_last(ic_last), .ifm_win(ifm_win), .weight(weight), .bias_in(bias_in),
        .bias_valid(bias_valid), .act_mode(act_mode), .out_shift(out_shift),
        .out_valid(out_valid), .ofm(ofm), .sat_any(sat_any), .err_seq(err_seq)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running, required finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_bad  = 0;
    int n_outv = 0;
    logic [OFM_W:0] exp_q[$];
    int             exp_cyc_q[$];

    int ifm_a [N_ICH][TAPS];
    int w_a   [N_OCH][N_ICH][TAPS];
    int bias_a[N_OCH];
    int m_bias[N_OCH];
    int m_acc [N_OCH];
    bit m_open;
    bit m_err;

    task automatic check_val(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int requant(input int acc, input int mode, input int shift, output bit clip);
        longint x;
        x = longint'(acc);
        if (shift > 0) x = x + (longint'(1) << (shift - 1));
        x = x >>> shift;
        if (x < 0 && mode == 1) x = 0;
        else if (x < 0 && mode == 2) x = x >>> 3;
        clip = 1'b0;
        if (x > OUT_MAX) begin
            x = OUT_MAX;
            clip = 1'b1;
        end else if (x < OUT_MIN) begin
            x = OUT_MIN;
            clip = 1'b1;
        end
        return int'(x);
    endfunction

    task automatic model_reset();
        for (int o = 0; o < N_OCH; o++) begin
            m_bias[o] = 0;
            m_acc[o]  = 0;
        end
        m_open = 1'b0;
        m_err  = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    task automatic model_beat(input bit first, input bit last, input int mode, input int shift);
        bit             start;
        bit             clip;
        bit             any;
        int             dot;
        int             r;
        logic [OFM_W:0] e;
        start = first || !m_open;
        if (!first && !m_open) m_err = 1'b1;
        if (first && m_open) m_err = 1'b1;
        for (int o = 0; o < N_OCH; o++) begin
            dot = 0;
            for (int i = 0; i < N_ICH; i++)
                for (int k = 0; k < TAPS; k++)
                    dot += ifm_a[i][k] * w_a[o][i][k];
            m_acc[o] = start ? (m_bias[o] + dot) : (m_acc[o] + dot);
        end
        if (last) begin
            m_open = 1'b0;
            any = 1'b0;
            e = '0;
            for (int o = 0; o < N_OCH; o++) begin
                r = requant(m_acc[o], mode, shift, clip);
                e[o*OUT_W +: OUT_W] = r[OUT_W-1:0];
                any = any | clip;
            end
            e[OFM_W] = any;
            exp_q.push_back(e);
            exp_cyc_q.push_back(cycle_cnt + 5);
        end else begin
            m_open = 1'b1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic fill_const(input int iv, input int wv);
        for (int i = 0; i < N_ICH; i++)
            for (int k = 0; k < TAPS; k++) ifm_a[i][k] = iv;
        for (int o = 0; o < N_OCH; o++)
            for (int i = 0; i < N_ICH; i++)
                for (int k = 0; k < TAPS; k++) w_a[o][i][k] = wv;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N_ICH; i++)
            for (int k = 0; k < TAPS; k++) ifm_a[i][k] = int'($urandom_range(0, 255)) - 128;
        for (int o = 0; o < N_OCH; o++)
            for (int i = 0; i < N_ICH; i++)
                for (int k = 0; k < TAPS; k++) w_a[o][i][k] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic rand_bias();
        for (int o = 0; o < N_OCH; o++) bias_a[o] = int'($urandom_range(0, 262143)) - 131072;
    endtask

    task automatic const_bias(input int b);
        for (int o = 0; o < N_OCH; o++) bias_a[o] = b;
    endtask

    task automatic pack_inputs();
        for (int i = 0; i < N_ICH; i++)
            for (int k = 0; k < TAPS; k++)
                ifm_win[(i*TAPS+k)*DATA_W +: DATA_W] = DATA_W'(ifm_a[i][k]);
        for (int o = 0; o < N_OCH; o++)
            for (int i = 0; i < N_ICH; i++)
                for (int k = 0; k < TAPS; k++)
                    weight[((o*N_ICH+i)*TAPS+k)*DATA_W +: DATA_W] = DATA_W'(w_a[o][i][k]);
        for (int o = 0; o < N_OCH; o++) bias_in[o*BIAS_W +: BIAS_W] = BIAS_W'(bias_a[o]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_bias();
        pack_inputs();
        bias_valid = 1'b1;
        @(posedge clk);
        #1;
        bias_valid = 1'b0;
        m_bias = bias_a;
    endtask

    task automatic drive_beat(input bit first, input bit last, input int mode, input int shift, input bit load);
        pack_inputs();
        bias_valid = load;
        in_valid   = 1'b1;
        ic_first   = first;
        ic_last    = last;
        act_mode   = 2'(mode);
        out_shift  = 5'(shift);
        model_beat(first, last, mode, shift);
        if (load) m_bias = bias_a;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        bias_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_val("drain_outputs_seen", exp_q.size(), 0);
        exp_q.delete();
        exp_cyc_q.delete();
        idle(2);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [OFM_W:0] e;
        int             ec;
        if (out_valid) begin
            n_outv++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_out: out_valid=1 ofm=%h, required no output", ofm);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if ({sat_any, ofm} !== e) begin
                    n_bad++;
                    $display("FAIL ofm_check: got sat=%0b ofm=%h, required sat=%0b ofm=%h",
                             sat_any, ofm, e[OFM_W], e[OFM_W-1:0]);
                end
                check_val("out_latency_cycle", cycle_cnt, ec);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int  len;
        int  mode;
        int  shift;
        int  outv_before;
        bit  first;
        bit  last;
        bit  load;

        rst = 1'b1; in_valid = 1'b0; ic_first = 1'b0; ic_last = 1'b0;
        ifm_win = '0; weight = '0; bias_in = '0; bias_valid = 1'b0;
        act_mode = 2'd0; out_shift = 5'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_ofm_nonzero", |ofm, 0);
        check_val("rst_sat_any", sat_any, 0);
        check_val("rst_err_seq", err_seq, 0);

        // basic 77, then requant shift 2 -> 19
        const_bias(5);
        load_bias();
        fill_const(1, 1);
        drive_beat(1, 1, 0, 0, 0);
        drive_beat(1, 1, 0, 2, 0);
        drain();

        // 3-beat group with a gap -> 1286
        const_bias(-10);
        load_bias();
        fill_const(2, 3);
        drive_beat(1, 0, 0, 0, 0);
        drive_beat(0, 0, 0, 0, 0);
        idle(1);
        drive_beat(0, 1, 0, 0, 0);
        drain();

        // saturation both directions
        fill_const(127, 127);
        for (int b = 0; b < 4; b++) drive_beat(b == 0, b == 3, 0, 0, 0);
        fill_const(127, -128);
        for (int b = 0; b < 4; b++) drive_beat(b == 0, b == 3, 0, 0, 0);
        drain();

        // activation on -100 in all four modes
        const_bias(-100);
        load_bias();
        fill_const(0, 0);
        for (int m = 0; m < 4; m++) drive_beat(1, 1, m, 0, 0);
        drain();
        check_val("err_seq_clean", err_seq, m_err);

        // non-first beat while idle behaves as a first beat
        fill_const(1, 1);
        drive_beat(0, 1, 0, 0, 0);
        drain();
        check_val("err_seq_set", err_seq, m_err);

        // reset in the middle of a group drops it
        const_bias(5);
        load_bias();
        drive_beat(1, 0, 0, 0, 0);
        in_valid = 1'b1; ic_first = 1'b0; ic_last = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_reset();
        outv_before = n_outv;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(8);
        check_val("rst_mid_group_outputs", n_outv - outv_before, 0);
        check_val("rst_clears_err_seq", err_seq, 0);
        const_bias(5);
        load_bias();
        drive_beat(1, 1, 0, 0, 0);
        drain();

        // back-to-back singles, new bias loaded alongside beat 3
        rand_bias();
        load_bias();
        for (int b = 0; b < 4; b++) begin
            fill_rand();
            load = (b == 2);
            if (load) rand_bias();
            drive_beat(1, 1, 0, 4, load);
        end
        drain();

        // randomised groups with gaps, bias loads and sequencing errors
        for (int g = 0; g < 40; g++) begin
            len   = $urandom_range(1, 4);
            mode  = $urandom_range(0, 3);
            shift = $urandom_range(0, 20);
            for (int b = 0; b < len; b++) begin
                first = (b == 0);
                last  = (b == len - 1);
                if ($urandom_range(0, 15) == 0) first = !first;
                load = ($urandom_range(0, 7) == 0);
                fill_rand();
                if (load) rand_bias();
                drive_beat(first, last, mode, shift, load);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        drain();
        check_val("err_seq_final", err_seq, m_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
